store_access: RTL and testbench

Write-side counterpart of the memory-access stage in the SIMPLE multi-phase datapath. Phase 4 of an instruction is the memory phase. In that phase the block either issues a single-cycle memory write (store) or presents a word on the external output port (OUT) using a valid/ready handshake. While the output handshake is pending, it stalls the phase sequencer. It sits beside the MDR load path and drives the memory write port and the external output pins.

---
 rtl/simple_pkg.sv | 20 ++
 rtl/store_access_if.sv | 35 +++
 rtl/store_access_out_port_ctrl.sv | 84 ++++++++
 rtl/store_access.sv | 110 +++++++++++
 tb/tb_store_access.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/simple_pkg.sv
// simple_pkg: definitions shared by the SIMPLE datapath stages
// (phase sequencer, MDR load path, store_access).
//   state_e    : store/output stage FSM states
//   PHASE_MEM  : phase_counter value of the memory phase
//   is_phase   : helper comparing a phase counter against a target phase
package simple_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WRITE    = 2'd1,
    ST_OUT_WAIT = 2'd2
  } state_e;

  localparam logic [2:0] PHASE_MEM = 3'b100;

  function automatic logic is_phase(input logic [2:0] phase, input logic [2:0] target);
    return phase == target;
  endfunction

endpackage

// File: rtl/store_access_if.sv
// store_access_if: bundles the memory-phase control inputs, the memory
// write port and the OUT valid/ready port of store_access.
//   slave  : view of the store_access block itself
//   master : view of the surrounding datapath / sink (drives inputs)
// Signals (original pin names kept):
//   phase_counter, op_store, op_out, address_bus, data_bus, out_ready  -> into block
//   mem_addr, mem_wdata, mem_we, outside_output, out_valid, stall,
//   out_timeout                                                         -> out of block
interface store_access_if #(
  parameter int unsigned WIDTH = 16
);
  logic [2:0]       phase_counter;
  logic             op_store;
  logic             op_out;
  logic [WIDTH-1:0] address_bus;
  logic [WIDTH-1:0] data_bus;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_we;
  logic [WIDTH-1:0] outside_output;
  logic             out_valid;
  logic             out_ready;
  logic             stall;
  logic             out_timeout;

  modport slave (
    input  phase_counter, op_store, op_out, address_bus, data_bus, out_ready,
    output mem_addr, mem_wdata, mem_we, outside_output, out_valid, stall, out_timeout
  );

  modport master (
    output phase_counter, op_store, op_out, address_bus, data_bus, out_ready,
    input  mem_addr, mem_wdata, mem_we, outside_output, out_valid, stall, out_timeout
  );
endinterface

// File: rtl/store_access_out_port_ctrl.sv
// out_port_ctrl: external OUT port of the memory phase.
// Holds the output word register and out_valid, reports a transfer
// (valid && ready) and, when OUT_TIMEOUT_EN is defined, counts wait cycles
// and aborts the handshake after TIMEOUT_CYCLES cycles without a transfer.
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   capture_i         : load data_i and raise valid (OUT start)
//   data_i            : word to present
//   out_ready_i       : sink ready
//   out_word_o        : registered output word (held after transfer)
//   out_valid_o       : output word valid
//   xfer_o            : transfer this cycle (combinational)
//   abort_o           : timeout abort this cycle (combinational, 0 if disabled)
//   out_timeout_o     : sticky timeout flag (0 if disabled)
// Configuration macro: OUT_TIMEOUT_EN
module out_port_ctrl #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             capture_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_word_o,
  output logic             out_valid_o,
  output logic             xfer_o,
  output logic             abort_o,
  output logic             out_timeout_o
);

  logic [WIDTH-1:0] word_q;
  logic             valid_q;

  assign xfer_o = valid_q && out_ready_i;

  always_ff @(posedge clock) begin
    if (reset) begin
      word_q  <= '0;
      valid_q <= 1'b0;
    end else if (capture_i) begin
      word_q  <= data_i;
      valid_q <= 1'b1;
    end else if (xfer_o || abort_o) begin
      valid_q <= 1'b0;
    end
  end

`ifdef OUT_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic          flag_q;

  // A ready sink in the final wait cycle still transfers; abort needs !ready.
  assign abort_o = valid_q && !out_ready_i && (cnt_q == LAST_WAIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      if (capture_i) begin
        cnt_q <= '0;
      end else if (valid_q && !xfer_o) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (abort_o) begin
        flag_q <= 1'b1;
      end
    end
  end

  assign out_timeout_o = flag_q;
`else
  assign abort_o       = 1'b0;
  assign out_timeout_o = 1'b0;
`endif

  assign out_word_o  = word_q;
  assign out_valid_o = valid_q;

endmodule

// File: rtl/store_access.sv
// store_access: write side of the memory phase. In phase PHASE_MEM it either
// issues a one-cycle memory write (store) or presents a word on the OUT port
// with a valid/ready handshake, stalling the phase sequencer until the
// transfer (or a timeout abort) happens.
// Ports:
//   clock  : single clock, posedge
//   reset  : synchronous, active-high
//   bus    : store_access_if.slave (phase/op decode, address/data buses,
//            memory write port, OUT port, stall, out_timeout)
// Parameters: WIDTH, PHASE_MEM, TIMEOUT_CYCLES (used with OUT_TIMEOUT_EN)
// Configuration macro: OUT_TIMEOUT_EN (OUT timeout abort + sticky flag)
module store_access #(
  parameter int unsigned WIDTH          = 16,
  parameter logic [2:0]  PHASE_MEM      = 3'b100,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic           clock,
  input logic           reset,
  store_access_if.slave bus
);
  import simple_pkg::*;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             we_q, we_d;

  logic             mem_phase;
  logic             store_start;
  logic             out_start;
  logic             xfer;
  logic             abort;
  logic             out_valid;

  assign mem_phase = is_phase(bus.phase_counter, PHASE_MEM);
  // A store wins over a simultaneous OUT decode.
  assign store_start = (state_q == ST_IDLE) && mem_phase && bus.op_store;
  assign out_start   = (state_q == ST_IDLE) && mem_phase && bus.op_out && !bus.op_store;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (store_start) begin
          addr_d  = bus.address_bus;
          wdata_d = bus.data_bus;
          we_d    = 1'b1;
          state_d = ST_WRITE;
        end else if (out_start) begin
          state_d = ST_OUT_WAIT;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      ST_OUT_WAIT: begin
        if (xfer || abort) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  out_port_ctrl #(
    .WIDTH          (WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_out_port_ctrl (
    .clock         (clock),
    .reset         (reset),
    .capture_i     (out_start),
    .data_i        (bus.data_bus),
    .out_ready_i   (bus.out_ready),
    .out_word_o    (bus.outside_output),
    .out_valid_o   (out_valid),
    .xfer_o        (xfer),
    .abort_o       (abort),
    .out_timeout_o (bus.out_timeout)
  );

  // Stall the capture cycle as well, so the phase stays at PHASE_MEM until
  // the transfer edge and the instruction is not re-triggered.
  assign bus.stall = out_start ||
                     ((state_q == ST_OUT_WAIT) && !bus.out_ready && !abort);

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = we_q;
  assign bus.out_valid = out_valid;

endmodule

// File: tb/tb_store_access.sv
module tb_store_access;

  localparam int unsigned W  = 16;
  localparam int unsigned TO = 4;
`ifdef OUT_TIMEOUT_EN
  localparam int unsigned MAX_DLY = TO - 1;
`else
  localparam int unsigned MAX_DLY = 8;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  store_access_if #(.WIDTH(W)) bus ();

  store_access #(
    .WIDTH          (W),
    .PHASE_MEM      (3'b100),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: architectural values the outputs must show.
  logic [W-1:0] exp_addr    = '0;
  logic [W-1:0] exp_wdata   = '0;
  logic [W-1:0] exp_out     = '0;
  logic         exp_timeout = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.phase_counter = 3'd0;
    bus.op_store      = 1'b0;
    bus.op_out        = 1'b0;
    bus.address_bus   = W'($urandom);
    bus.data_bus      = W'($urandom);
  endtask

  task automatic do_store(input logic [W-1:0] a, input logic [W-1:0] d, input logic both);
    bus.phase_counter = 3'd4;
    bus.op_store      = 1'b1;
    bus.op_out        = both;
    bus.address_bus   = a;
    bus.data_bus      = d;
    #1;
    check("st_cap_stall", 32'(bus.stall), 0);
    check("st_cap_we", 32'(bus.mem_we), 0);
    tick();
    exp_addr  = a;
    exp_wdata = d;
    idle_inputs();
    #1;
    check("st_we", 32'(bus.mem_we), 1);
    check("st_addr", 32'(bus.mem_addr), 32'(exp_addr));
    check("st_wdata", 32'(bus.mem_wdata), 32'(exp_wdata));
    check("st_stall", 32'(bus.stall), 0);
    check("st_valid", 32'(bus.out_valid), 0);
    tick();
    #1;
    check("st_we_off", 32'(bus.mem_we), 0);
    check("st_addr_hold", 32'(bus.mem_addr), 32'(exp_addr));
    check("st_wdata_hold", 32'(bus.mem_wdata), 32'(exp_wdata));
    check("st_out_hold", 32'(bus.outside_output), 32'(exp_out));
    check("st_valid_off", 32'(bus.out_valid), 0);
    check("st_timeout", 32'(bus.out_timeout), 32'(exp_timeout));
  endtask

  // OUT with the sink ready after dly wait cycles (dly=0: ready at once).
  task automatic do_out(input logic [W-1:0] d, input int unsigned dly);
    int unsigned stall_cycles;
    bus.phase_counter = 3'd4;
    bus.op_store      = 1'b0;
    bus.op_out        = 1'b1;
    bus.data_bus      = d;
    bus.out_ready     = (dly == 0);
    #1;
    check("out_cap_stall", 32'(bus.stall), 1);
    check("out_cap_valid", 32'(bus.out_valid), 0);
    stall_cycles = 32'(bus.stall);
    exp_out = d;
    for (int unsigned w = 0; w <= dly; w++) begin
      tick();
      bus.out_ready = (w >= dly);
      bus.data_bus  = W'($urandom);
      #1;
      check("out_wait_valid", 32'(bus.out_valid), 1);
      check("out_wait_word", 32'(bus.outside_output), 32'(exp_out));
      check("out_wait_stall", 32'(bus.stall), 32'(w < dly));
      check("out_wait_we", 32'(bus.mem_we), 0);
      stall_cycles += 32'(bus.stall);
    end
    tick();
    idle_inputs();
    bus.out_ready = 1'($urandom);
    #1;
    check("out_done_valid", 32'(bus.out_valid), 0);
    check("out_done_hold", 32'(bus.outside_output), 32'(exp_out));
    check("out_done_stall", 32'(bus.stall), 0);
    check("out_stall_cycles", stall_cycles, dly + 1);
    check("out_timeout", 32'(bus.out_timeout), 32'(exp_timeout));
  endtask

  initial begin
    idle_inputs();
    bus.out_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    check("rst_addr", 32'(bus.mem_addr), 0);
    check("rst_wdata", 32'(bus.mem_wdata), 0);
    check("rst_we", 32'(bus.mem_we), 0);
    check("rst_out", 32'(bus.outside_output), 0);
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_stall", 32'(bus.stall), 0);
    check("rst_timeout", 32'(bus.out_timeout), 0);
    reset = 1'b0;
    tick();

    do_store(16'h0010, 16'hBEEF, 1'b0);
    bus.out_ready = 1'b1;
    do_out(16'h1234, 0);
    do_out(16'h5A5A, (MAX_DLY >= 5) ? 5 : MAX_DLY);
    do_store(16'h0020, 16'hCAFE, 1'b1);

    // Reset while an OUT handshake is pending.
    bus.out_ready     = 1'b0;
    bus.phase_counter = 3'd4;
    bus.op_out        = 1'b1;
    bus.data_bus      = 16'h7777;
    tick();
    #1;
    check("mid_valid", 32'(bus.out_valid), 1);
    reset = 1'b1;
    idle_inputs();
    tick();
    exp_addr = '0; exp_wdata = '0; exp_out = '0; exp_timeout = 1'b0;
    check("mid_rst_valid", 32'(bus.out_valid), 0);
    check("mid_rst_stall", 32'(bus.stall), 0);
    check("mid_rst_out", 32'(bus.outside_output), 0);
    check("mid_rst_we", 32'(bus.mem_we), 0);
    check("mid_rst_addr", 32'(bus.mem_addr), 0);
    reset = 1'b0;
    tick();

`ifdef OUT_TIMEOUT_EN
    bus.phase_counter = 3'd4;
    bus.op_out        = 1'b1;
    bus.data_bus      = 16'h0BAD;
    bus.out_ready     = 1'b0;
    exp_out           = 16'h0BAD;
    for (int unsigned w = 1; w <= TO; w++) begin
      tick();
      #1;
      check("to_valid", 32'(bus.out_valid), 1);
      check("to_stall", 32'(bus.stall), 32'(w < TO));
      check("to_flag_pre", 32'(bus.out_timeout), 0);
    end
    tick();
    exp_timeout = 1'b1;
    idle_inputs();
    #1;
    check("to_valid_off", 32'(bus.out_valid), 0);
    check("to_flag", 32'(bus.out_timeout), 1);
    check("to_word", 32'(bus.outside_output), 32'(exp_out));
    do_store(16'h00A0, 16'h1111, 1'b0);
`endif

    // Randomized mix of stores, OUTs and non-memory phases.
    for (int unsigned i = 0; i < 40; i++) begin
      int unsigned kind;
      kind = $urandom_range(0, 3);
      case (kind)
        0: do_store(W'($urandom), W'($urandom), 1'b0);
        1: do_store(W'($urandom), W'($urandom), 1'b1);
        2: do_out(W'($urandom), $urandom_range(0, MAX_DLY));
        default: begin
          bus.phase_counter = 3'($urandom_range(0, 3));
          bus.op_store      = 1'($urandom);
          bus.op_out        = 1'($urandom);
          bus.address_bus   = W'($urandom);
          bus.data_bus      = W'($urandom);
          bus.out_ready     = 1'($urandom);
          #1;
          check("np_stall", 32'(bus.stall), 0);
          tick();
          check("np_we", 32'(bus.mem_we), 0);
          check("np_valid", 32'(bus.out_valid), 0);
          check("np_addr", 32'(bus.mem_addr), 32'(exp_addr));
          check("np_out", 32'(bus.outside_output), 32'(exp_out));
          idle_inputs();
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
